// File: rtl/note_cmd_sequencer.sv
// Command sequencer between a 32-bit command FIFO and a square-tone / envelope pair.
// Fetches one word, executes it for one cycle, and optionally sits in a timed WAIT.
module note_cmd_sequencer #(
  parameter int TICK_DIV = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [31:0] fifo_data,
  output logic [22:0] period,
  output logic        note_on,
  output logic        note_off,
  output logic        gate,
  output logic        waiting,
  output logic        bad_cmd
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT} state_t;

  localparam logic [3:0]  OP_NOP      = 4'h0;
  localparam logic [3:0]  OP_NOTE_ON  = 4'h1;
  localparam logic [3:0]  OP_NOTE_OFF = 4'h2;
  localparam logic [3:0]  OP_WAIT     = 4'h3;
  localparam logic [15:0] PRE_LAST    = 16'(TICK_DIV - 1);

  state_t      state, next_state;
  logic [27:0] tick_cnt;
  logic [15:0] pre_cnt;
  logic [3:0]  opcode;
  logic [22:0] note_period;
  logic [27:0] wait_count;
  logic        fetch;
  logic        on_cmd, off_cmd, wait_cmd, bad_op;
  logic        tick, last_tick;

  assign opcode      = fifo_data[31:28];
  assign note_period = fifo_data[22:0];
  assign wait_count  = fifo_data[27:0];

  // Decode is only meaningful in EXEC, where fifo_data holds the word fetched last cycle.
  always_comb begin
    on_cmd   = 1'b0;
    off_cmd  = 1'b0;
    wait_cmd = 1'b0;
    bad_op   = 1'b0;
    if (state == S_EXEC) begin
      case (opcode)
        OP_NOP:      ;
        OP_NOTE_ON:  if (note_period != '0) on_cmd = 1'b1;
                     else                   off_cmd = 1'b1;
        OP_NOTE_OFF: off_cmd  = 1'b1;
        OP_WAIT:     wait_cmd = 1'b1;
        default:     bad_op   = 1'b1;
      endcase
    end
  end

  assign tick      = (state == S_WAIT) && enable && (pre_cnt == PRE_LAST);
  assign last_tick = tick && (tick_cnt == 28'd1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (fetch) next_state = S_EXEC;
      S_EXEC: next_state = (wait_cmd && wait_count != '0) ? S_WAIT : S_IDLE;
      S_WAIT: if (last_tick) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // FSM outputs; rst gates the read strobe so a held reset can never pop the FIFO.
  always_comb begin
    fetch      = (state == S_IDLE) && enable && !fifo_empty && !rst;
    fifo_rd_en = fetch;
    waiting    = (state == S_WAIT);
  end

  // WAIT timing: prescaler wraps every TICK_DIV enabled cycles, each wrap is one tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      pre_cnt  <= '0;
    end else if (wait_cmd) begin
      tick_cnt <= wait_count;
      pre_cnt  <= '0;
    end else if (state == S_WAIT && enable) begin
      if (tick) begin
        pre_cnt  <= '0;
        tick_cnt <= tick_cnt - 28'd1;
      end else begin
        pre_cnt  <= pre_cnt + 16'd1;
      end
    end
  end

  // Registered note outputs; pulses default low so each lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period   <= '0;
      gate     <= 1'b0;
      note_on  <= 1'b0;
      note_off <= 1'b0;
      bad_cmd  <= 1'b0;
    end else begin
      note_on  <= on_cmd;
      note_off <= off_cmd && gate;
      bad_cmd  <= bad_op;
      if (on_cmd) begin
        period <= note_period;
        gate   <= 1'b1;
      end else if (off_cmd) begin
        period <= '0;
        gate   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_note_cmd_sequencer.sv
// Bench for note_cmd_sequencer: FIFO model, command-level reference model checked
// every cycle, directed scenarios and a randomized command stream.
module tb_note_cmd_sequencer;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst, enable, fifo_empty, fifo_rd_en;
  logic [31:0] fifo_data;
  logic [22:0] period;
  logic        note_on, note_off, gate, waiting, bad_cmd;

  note_cmd_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .period(period),
    .note_on(note_on), .note_off(note_off), .gate(gate),
    .waiting(waiting), .bad_cmd(bad_cmd)
  );

  always #5 clk = ~clk;

  // Upstream FIFO with 1-cycle read latency
  logic [31:0] mem [0:2047];
  int wp = 0, rp = 0;
  assign fifo_empty = (wp == rp);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rp];
      rp        <= rp + 1;
    end
  end

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a fetched word takes effect two cycles after the fetch;
  // a WAIT of c ticks keeps waiting high for c*TD enabled cycles.
  logic        m_exec = 0;
  logic [31:0] m_word;
  int          m_wait_left = 0;
  logic [22:0] m_period = 0;
  logic        m_gate = 0, m_on = 0, m_off = 0, m_bad = 0, m_waiting = 0;
  int cyc = 0, run = 0, last_wait_len = 0;
  int cnt_on = 0, cnt_off = 0, cnt_bad = 0, cnt_rd = 0, last_rd_cyc = 0, last_on_cyc = 0;

  task automatic m_off_cmd();
    m_off    = m_gate;
    m_period = '0;
    m_gate   = 1'b0;
  endtask

  initial begin
    logic exp_rd;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_period", period, 0);
        chk("rst_gate", gate, 0);
        chk("rst_pulses", {note_on, note_off, bad_cmd}, 0);
        chk("rst_waiting", waiting, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        m_exec = 0; m_wait_left = 0; m_period = 0; m_gate = 0;
        m_on = 0; m_off = 0; m_bad = 0; m_waiting = 0; run = 0;
      end else begin
        chk("period", period, m_period);
        chk("gate", gate, m_gate);
        chk("note_on", note_on, m_on);
        chk("note_off", note_off, m_off);
        chk("bad_cmd", bad_cmd, m_bad);
        chk("waiting", waiting, m_waiting);
        exp_rd = !m_exec && (m_wait_left == 0) && enable && (wp != rp);
        chk("rd_en", fifo_rd_en, exp_rd);
        if (note_on)    begin cnt_on++; last_on_cyc = cyc; end
        if (note_off)   cnt_off++;
        if (bad_cmd)    cnt_bad++;
        if (fifo_rd_en) begin cnt_rd++; last_rd_cyc = cyc; end
        if (waiting) run++;
        else if (run > 0) begin last_wait_len = run; run = 0; end
        m_on = 0; m_off = 0; m_bad = 0;
        if (m_exec) begin
          m_exec = 0;
          case (m_word[31:28])
            4'h0: ;
            4'h1: if (m_word[22:0] != 0) begin
                    m_on = 1; m_period = m_word[22:0]; m_gate = 1;
                  end else m_off_cmd();
            4'h2: m_off_cmd();
            4'h3: m_wait_left = int'(m_word[27:0]) * TD;
            default: m_bad = 1;
          endcase
        end else if (m_wait_left > 0 && enable) begin
          m_wait_left--;
        end
        m_waiting = (m_wait_left > 0);
        if (exp_rd) begin m_exec = 1; m_word = mem[rp]; end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wp] = w;
    wp++;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 3000; k++) begin
      if (wp == rp && !m_exec && m_wait_left == 0) break;
      step();
    end
    if (k == 3000) chk("idle_timeout", 0, 1);
    step(2);
  endtask

  function automatic logic [31:0] rand_word();
    int r = $urandom_range(9);
    logic [31:0] w = $urandom;
    if (r == 0)      w[31:28] = 4'h0;
    else if (r <= 3) begin
      w[31:28] = 4'h1;
      if ($urandom_range(7) == 0) w[22:0] = '0;
    end
    else if (r <= 5) w[31:28] = 4'h2;
    else if (r <= 7) w = 32'h3000_0000 | 32'($urandom_range(5));
    else             w[31:28] = 4'($urandom_range(15, 4));
    return w;
  endfunction

  int b_on, b_off, b_bad, b_rd;
  initial begin
    rst = 1; enable = 0;
    step(3);
    rst = 0; enable = 1;
    step(2);

    // NOTE_ON: single rd_en, outputs two cycles later
    b_on = cnt_on; b_rd = cnt_rd;
    push(32'h1000_1234);
    wait_idle();
    chk("t1_rd_cnt", cnt_rd - b_rd, 1);
    chk("t1_on_cnt", cnt_on - b_on, 1);
    chk("t1_latency", last_on_cyc - last_rd_cyc, 2);
    chk("t1_period", period, 23'h001234);
    chk("t1_gate", gate, 1);

    // WAIT 3 ticks at TD=4 then NOTE_OFF
    b_off = cnt_off;
    push(32'h3000_0003); push(32'h2000_0000);
    wait_idle();
    chk("t2_wait_len", last_wait_len, 12);
    chk("t2_off_cnt", cnt_off - b_off, 1);
    chk("t2_period", period, 0);

    // NOTE_OFF with gate low; NOTE_ON with zero period acts as NOTE_OFF
    b_off = cnt_off;
    push(32'h2000_0000);
    wait_idle();
    chk("t3_off_gate0", cnt_off - b_off, 0);
    push(32'h1000_0055);
    wait_idle();
    b_off = cnt_off; b_on = cnt_on;
    push(32'h1000_0000);
    wait_idle();
    chk("t3_off_zero_on", cnt_off - b_off, 1);
    chk("t3_no_on", cnt_on - b_on, 0);
    chk("t3_gate", gate, 0);

    // Retrigger then unknown opcode
    push(32'h1000_0777); push(32'h1000_0123);
    b_bad = cnt_bad; b_off = cnt_off;
    push(32'h7FFF_FFFF);
    wait_idle();
    chk("t4_bad_cnt", cnt_bad - b_bad, 1);
    chk("t4_no_off", cnt_off - b_off, 0);
    chk("t4_period", period, 23'h000123);
    chk("t4_gate", gate, 1);

    // Enable dropped 10 cycles mid-WAIT
    push(32'h3000_0005);
    for (int k = 0; k < 20 && !waiting; k++) step();
    step(6);
    enable = 0;
    step(10);
    enable = 1;
    wait_idle();
    chk("t5_wait_len", last_wait_len, 5 * TD + 10);
    for (int k = 0; k < 5; k++) begin chk("t5_rd_empty", fifo_rd_en, 0); step(); end
    enable = 0;
    push(32'h0000_0000);
    for (int k = 0; k < 4; k++) begin chk("t5_rd_disabled", fifo_rd_en, 0); step(); end
    enable = 1;
    wait_idle();

    // Reset mid-WAIT, then normal fetch
    push(32'h3000_0010);
    for (int k = 0; k < 20 && !waiting; k++) step();
    step(5);
    rst = 1;
    #1;
    chk("t6_waiting", waiting, 0);
    chk("t6_gate", gate, 0);
    chk("t6_period", period, 0);
    step(2);
    rst = 0;
    step();
    b_on = cnt_on;
    push(32'h1000_0099);
    wait_idle();
    chk("t6_on_cnt", cnt_on - b_on, 1);
    chk("t6_period_after", period, 23'h000099);

    // Reset during EXEC: the word is lost, not re-read
    b_on = cnt_on; b_rd = cnt_rd;
    push(32'h1000_0ABC);
    step();
    rst = 1;
    step(2);
    rst = 0;
    wait_idle();
    chk("t7_rd_cnt", cnt_rd - b_rd, 1);
    chk("t7_on_cnt", cnt_on - b_on, 0);
    chk("t7_period", period, 0);

    // Randomized command stream with enable jitter and occasional reset
    for (int i = 0; i < 200; i++) begin
      int n = $urandom_range(3, 1);
      for (int j = 0; j < n; j++) push(rand_word());
      for (int c = 0; c < 40; c++) begin
        enable = ($urandom_range(7) != 0);
        if ($urandom_range(400) == 0) rst = 1;
        step();
        rst = 0;
      end
      enable = 1;
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/note_cmd_sequencer.md
NOTE_CMD_SEQUENCER -- requirements
Module: note_cmd_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 48, meaning clk cycles per WAIT tick (1 us at 48 MHz); legal range 1..65535.
REQ-002 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port enable  in  1  run permission; low pauses fetch and WAIT countdown.
REQ-005 SHALL have port fifo_empty  in  1  empty flag of the upstream 32-bit standard FIFO, which has 1-cycle read latency.
REQ-006 SHALL have port fifo_rd_en  out  1  FIFO read strobe.
REQ-007 SHALL have port fifo_data  in  32  FIFO read data, valid the cycle after fifo_rd_en.
REQ-008 SHALL have port period  out  23  tone period to the square generator; 0 means silent.
REQ-009 SHALL have port note_on  out  1  one-cycle pulse to the envelope generator.
REQ-010 SHALL have port note_off  out  1  one-cycle pulse to the envelope generator.
REQ-011 SHALL have port gate  out  1  high while a note is sounding.
REQ-012 SHALL have port waiting  out  1  high while in WAIT.
REQ-013 SHALL have port bad_cmd  out  1  one-cycle pulse on an unknown opcode.

Function
REQ-014 SHALL implement the states IDLE, EXEC and WAIT.
REQ-015 In IDLE, fifo_rd_en SHALL be driven combinationally as (enable && !fifo_empty); when it is high, the next state SHALL be EXEC.
REQ-016 fifo_rd_en SHALL never be high outside IDLE or while fifo_empty is high, so at most one word is read per two cycles.
REQ-017 EXEC SHALL last exactly one cycle and decode fifo_data[31:28] as the opcode; EXEC SHALL complete even if enable falls.
REQ-018 Opcode 0x0 (NOP) SHALL have no effect; next state IDLE.
REQ-019 Opcode 0x1 (NOTE_ON) with fifo_data[22:0] nonzero SHALL set period <= fifo_data[22:0] and gate <= 1, and pulse note_on; next state IDLE.
REQ-020 A NOTE_ON while gate is already 1 SHALL retrigger: note_on pulses again, period updates, and note_off is not pulsed.
REQ-021 A NOTE_ON with fifo_data[22:0] == 0 SHALL be executed exactly as NOTE_OFF.
REQ-022 Opcode 0x2 (NOTE_OFF) SHALL set period <= 0 and gate <= 0; note_off SHALL pulse only if gate was 1; next state IDLE.
REQ-023 Opcode 0x3 (WAIT) SHALL load a 28-bit tick counter from fifo_data[27:0] and clear the prescaler; if the count is 0, next state IDLE, otherwise WAIT.
REQ-024 Opcodes 0x4..0xF SHALL pulse bad_cmd and otherwise be ignored; next state IDLE.
REQ-025 In WAIT, the prescaler SHALL count TICK_DIV clk cycles per tick and the tick counter SHALL decrement on each tick; WAIT SHALL exit to IDLE in the cycle the counter reaches 0, giving exactly count*TICK_DIV cycles in WAIT.
REQ-026 While enable is low in WAIT, the prescaler and counter SHALL hold their values.
REQ-027 period, gate, note_on, note_off and bad_cmd SHALL be registered: for a fetch with fifo_rd_en high in cycle N, the outputs take effect in cycle N+2.
REQ-028 note_on, note_off and bad_cmd SHALL never be high for more than one consecutive cycle per command.
REQ-029 waiting SHALL equal (state == WAIT).

Reset
REQ-030 rst high SHALL immediately force state IDLE, clear the counters, and set period=0, gate=0, note_on=0, note_off=0, bad_cmd=0, waiting=0 and fifo_rd_en=0.
REQ-031 Reset asserted mid-WAIT or in EXEC SHALL abandon the command without pulses; the word already read SHALL be lost, and no re-read of it SHALL occur.

Verification
REQ-032 The bench SHALL cover: FIFO holds 0x1000_1234, enable=1 -> rd_en for one cycle, then period=0x001234, gate=1 and a single note_on pulse two cycles after rd_en.
REQ-033 The bench SHALL cover: TICK_DIV=4, words 0x3000_0003 then 0x2000_0000 -> waiting high for exactly 12 cycles, then note_off pulse and period=0.
REQ-034 The bench SHALL cover: 0x2000_0000 with gate=0 -> no note_off pulse; 0x1000_0000 with gate=1 -> note_off pulse and gate=0.
REQ-035 The bench SHALL cover: 0x7FFF_FFFF -> one bad_cmd pulse, with period and gate unchanged.
REQ-036 The bench SHALL cover: enable dropped for 10 cycles mid-WAIT -> total WAIT time extended by exactly 10 cycles; with fifo_empty=1, rd_en stays 0.
REQ-037 The bench SHALL cover: rst asserted during WAIT -> all outputs 0 that cycle, and the next word is fetched normally after release.
